gfx_wbm_read_sched: RTL and testbench

Three-master read scheduler for the GFX Wishbone read port. Shares the single wbm read module between the fragment processor (m0), the blender (m1) and the texture fetch unit (m2). Arbitration is registered: the winning request is latched and the grant is held for the whole bus transaction until `ack_i`. The blender has priority, bounded by a starvation limit.

---
 rtl/gfx_wbm_read_sched.sv | 78 +++++++
 tb/tb_gfx_wbm_read_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gfx_wbm_read_sched.sv
// gfx_wbm_read_sched: three-master registered read arbiter for the wbm read port, m1 priority with starvation limit
module gfx_wbm_read_sched #(
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        master_busy_o,
  output logic        read_request_o,
  output logic [31:2] addr_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        m0_read_request_i,
  input  logic [31:2] m0_addr_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic        m1_read_request_i,
  input  logic [31:2] m1_addr_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  input  logic        m2_read_request_i,
  input  logic [31:2] m2_addr_i,
  input  logic [3:0]  m2_sel_i,
  output logic [31:0] m2_dat_o,
  output logic        m2_ack_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] MAXC = 4'(MAX_CONSEC);
  state_t      state;
  logic [1:0]  grant, win;
  logic        rr, others, any_req, m1_win, bus_ack;
  logic [3:0]  consec;
  always_comb begin
    others  = m0_read_request_i | m2_read_request_i;
    any_req = others | m1_read_request_i;
    m1_win  = m1_read_request_i & (consec < MAXC | ~others);
    win     = m1_win ? 2'd1
            : (m0_read_request_i & m2_read_request_i) ? (rr ? 2'd2 : 2'd0)
            : m0_read_request_i ? 2'd0 : 2'd2;
    bus_ack = state == BUSY & ack_i;
  end
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      state          <= IDLE;
      read_request_o <= 1'b0;
      addr_o         <= '0;
      sel_o          <= '0;
      grant          <= 2'd0;
      rr             <= 1'b0;
      consec         <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        state          <= BUSY;
        read_request_o <= 1'b1;
        grant          <= win;
        addr_o         <= win == 2'd0 ? m0_addr_i : win == 2'd1 ? m1_addr_i : m2_addr_i;
        sel_o          <= win == 2'd0 ? m0_sel_i : win == 2'd1 ? m1_sel_i : m2_sel_i;
        if (m1_win)
          consec <= !others ? 4'd0 : consec == MAXC ? MAXC : consec + 4'd1;
        else begin
          consec <= 4'd0;
          rr     <= ~rr;
        end
      end
    end else if (ack_i) begin
      state          <= IDLE;
      read_request_o <= 1'b0;
    end
  assign m0_ack_o      = bus_ack & grant == 2'd0;
  assign m1_ack_o      = bus_ack & grant == 2'd1;
  assign m2_ack_o      = bus_ack & grant == 2'd2;
  assign m0_dat_o      = dat_i;
  assign m1_dat_o      = dat_i;
  assign m2_dat_o      = dat_i;
  assign master_busy_o = any_req | state == BUSY;
endmodule

// File: tb/tb_gfx_wbm_read_sched.sv
// tb_gfx_wbm_read_sched: directed scenarios plus random traffic against a transaction-level arbiter model
module tb_gfx_wbm_read_sched;
  localparam int MAXC = 4;
  logic        clk = 0, rst_i = 0, ack_i = 0;
  logic [31:0] dat_i = 0;
  logic [2:0]  req = 0;
  logic [29:0] addr [3];
  logic [3:0]  sel [3];
  logic        master_busy_o, read_request_o, m0_ack_o, m1_ack_o, m2_ack_o;
  logic [29:0] addr_o;
  logic [3:0]  sel_o;
  logic [31:0] m0_dat_o, m1_dat_o, m2_dat_o;
  int n_cmp = 0, n_bad = 0;
  // model of the arbiter at transaction level
  bit          m_busy = 0;
  int          m_g = 0, m_rr = 0, m_consec = 0, bc = 0;
  logic [29:0] m_addr = 0;
  logic [3:0]  m_sel = 0;
  bit          chk_en = 0, hold = 0;
  int          ackd = 1;
  logic [2:0]  drop = 0;
  int          obs[$], exp_q[$];

  gfx_wbm_read_sched #(.MAX_CONSEC(MAXC)) dut (
    .clk_i(clk), .rst_i(rst_i), .master_busy_o(master_busy_o), .read_request_o(read_request_o),
    .addr_o(addr_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i),
    .m0_read_request_i(req[0]), .m0_addr_i(addr[0]), .m0_sel_i(sel[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_read_request_i(req[1]), .m1_addr_i(addr[1]), .m1_sel_i(sel[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m2_read_request_i(req[2]), .m2_addr_i(addr[2]), .m2_sel_i(sel[2]), .m2_dat_o(m2_dat_o), .m2_ack_o(m2_ack_o));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_edge();
    int w;
    if (!rst_i) begin
      m_busy = 0; m_g = 0; m_rr = 0; m_consec = 0; m_addr = 0; m_sel = 0;
    end else if (m_busy) begin
      if (ack_i) m_busy = 0; else bc++;
    end else if (req != 0) begin
      bit rivals = req[0] || req[2];
      if (req[1] && (m_consec < MAXC || !rivals)) begin
        w = 1;
        m_consec = rivals ? (m_consec + 1 > MAXC ? MAXC : m_consec + 1) : 0;
      end else begin
        w = (req[0] && req[2]) ? (m_rr ? 2 : 0) : (req[0] ? 0 : 2);
        m_rr = 1 - m_rr;
        m_consec = 0;
      end
      m_g = w; m_busy = 1; bc = 0; m_addr = addr[w]; m_sel = sel[w];
    end
  endtask

  task automatic cyc();
    logic [2:0] want_ack, got_ack;
    #1;
    want_ack = (m_busy && ack_i) ? 3'(1 << m_g) : 3'b000;
    got_ack = {m2_ack_o, m1_ack_o, m0_ack_o};
    if (chk_en) begin
      check("rdreq", 32'(read_request_o), 32'(m_busy));
      check("addr", 32'(addr_o), 32'(m_addr));
      check("sel", 32'(sel_o), 32'(m_sel));
      check("acks", 32'(got_ack), 32'(want_ack));
      check("mbusy", 32'(master_busy_o), 32'((req != 0) || m_busy));
      check("dat", {m0_dat_o ^ dat_i} | {m1_dat_o ^ dat_i} | {m2_dat_o ^ dat_i}, 32'd0);
    end
    for (int n = 0; n < 3; n++) if (got_ack[n]) obs.push_back(n);
    if (!hold) drop = drop | want_ack;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic auto_step(bit rnd);
    req = req & ~drop;
    drop = 0;
    if (rnd)
      for (int n = 0; n < 3; n++)
        if (!req[n] && $urandom_range(3) == 0) begin
          req[n] = 1; addr[n] = 30'($urandom); sel[n] = 4'($urandom);
        end else if (req[n] && $urandom_range(9) == 0) addr[n] = 30'($urandom);
        else if (m_busy && m_g == n && $urandom_range(9) == 0) req[n] = 0;
    ack_i = rnd ? (m_busy ? $urandom_range(2) == 0 : $urandom_range(9) == 0) : (m_busy && bc == ackd);
    rst_i = rnd ? ($urandom_range(299) != 0) : 1'b1;
    dat_i = rnd ? $urandom : 32'hDEADBEEF;
    cyc();
  endtask

  task automatic reset_dut();
    rst_i = 0; req = 0; ack_i = 0;
    cyc();
    rst_i = 1; drop = 0; hold = 0; obs.delete();
  endtask

  task automatic run_until(int n);
    for (int k = 0; k < 120 && obs.size() < n; k++) auto_step(0);
  endtask

  task automatic chk_order(string tag);
    check({tag, "_count"}, obs.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs.size()) check(tag, obs[i], exp_q[i]);
    obs.delete();
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin addr[n] = 0; sel[n] = 0; end
    @(negedge clk);
    reset_dut();
    chk_en = 1;
    check("rst_rdreq", 32'(read_request_o), 0);
    check("rst_addr", 32'(addr_o), 0);
    check("rst_sel", 32'(sel_o), 0);
    check("rst_busy", 32'(master_busy_o), 0);
    // single m0 read, ack three cycles into BUSY
    req = 3'b001; addr[0] = 30'h400; sel[0] = 4'hF; ackd = 3;
    run_until(1);
    exp_q = '{0}; chk_order("m0_alone");
    check("m0_addr", 32'(addr_o), 32'h400);
    check("m0_sel", 32'(sel_o), 32'hF);
    // m1 beats m0 on a simultaneous request
    reset_dut();
    req = 3'b011; addr[1] = 30'h111; ackd = 1;
    run_until(2);
    exp_q = '{1, 0}; chk_order("m1_then_m0");
    // starvation limit with m1 and m2 always requesting
    reset_dut();
    hold = 1; req = 3'b110;
    run_until(10);
    req = 0; auto_step(0); auto_step(0); auto_step(0);
    exp_q = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2}; chk_order("starve");
    // m0/m2 round robin
    reset_dut();
    hold = 1; req = 3'b101;
    run_until(4);
    req = 0; auto_step(0); auto_step(0); auto_step(0);
    exp_q = '{0, 2, 0, 2}; chk_order("rr");
    // m2 changes address and drops request mid-transaction, then a stray ack in IDLE
    reset_dut();
    req = 3'b100; addr[2] = 30'h2AAA; sel[2] = 4'h3; ack_i = 0;
    cyc();
    addr[2] = 30'h1555; req[2] = 0;
    cyc();
    ack_i = 1; cyc();
    ack_i = 0; cyc();
    ack_i = 1; cyc();
    ack_i = 0;
    check("m2_addr_frozen", 32'(addr_o), 32'h2AAA);
    exp_q = '{2}; chk_order("m2_drop");
    // reset mid-transaction, late ack ignored, then a fresh grant
    reset_dut();
    req = 3'b001; addr[0] = 30'h777;
    cyc(); cyc();
    rst_i = 0; cyc();
    rst_i = 1; req = 0; ack_i = 1; cyc();
    ack_i = 0;
    check("rst_mid_rdreq", 32'(read_request_o), 0);
    check("rst_mid_addr", 32'(addr_o), 0);
    exp_q = '{}; chk_order("rst_mid");
    req = 3'b010; addr[1] = 30'h321; ackd = 0;
    run_until(1);
    exp_q = '{1}; chk_order("after_rst");
    // random traffic
    reset_dut();
    for (int k = 0; k < 4000; k++) auto_step(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
